// File: rtl/lsu1_dreq.sv
// LSU1-stage data-request engine: issues one sram-like data request per memory instruction,
// holds LSU1 until the address is accepted, and counts killed requests whose responses LSU2 drops.
module lsu1_dreq #(
  parameter int unsigned DROP_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exception_flush,
  input  logic        pipe_stall,
  input  logic        lsu1_ls_ena,
  input  logic [3:0]  lsu1_ls_sel,
  input  logic [31:0] lsu1_psyaddr,
  input  logic [31:0] lsu1_rt_data,
  input  logic        lsu1_has_exception,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  output logic        lsu1_stall_req,
  output logic        lsu1_req_issued,
  output logic        drop_pending
);

  typedef enum logic [1:0] {StIdle, StWait, StHeld, StKill} state_e;

  localparam logic [DROP_W-1:0] DropMax = {DROP_W{1'b1}};
  localparam logic [DROP_W-1:0] DropOne = {{(DROP_W-1){1'b0}}, 1'b1};

  state_e            state_q;
  logic [DROP_W-1:0] drop_cnt_q;
  logic              wr_q;
  logic [1:0]        size_q;
  logic [31:0]       addr_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       wdata_q;

  logic        enc_wr;
  logic [1:0]  enc_size;
  logic [3:0]  enc_wstrb;
  logic [31:0] enc_wdata;
  logic        ls_ok, drop_full, go;
  logic        drop_inc, drop_dec;

  always_comb begin
    enc_wr    = lsu1_ls_sel[3];
    enc_size  = 2'd2;
    enc_wstrb = 4'b0000;
    enc_wdata = 32'h0;
    case (lsu1_ls_sel)
      4'b0001, 4'b0010: enc_size = 2'd0;
      4'b0011, 4'b0100: enc_size = 2'd1;
      4'b1001: begin
        enc_size  = 2'd0;
        enc_wstrb = 4'b0001 << lsu1_psyaddr[1:0];
        enc_wdata = {4{lsu1_rt_data[7:0]}};
      end
      4'b1010: begin
        enc_size  = 2'd1;
        enc_wstrb = lsu1_psyaddr[1] ? 4'b1100 : 4'b0011;
        enc_wdata = {2{lsu1_rt_data[15:0]}};
      end
      4'b1011: begin
        enc_wstrb = 4'b1111;
        enc_wdata = lsu1_rt_data;
      end
      default: ;
    endcase
  end

  assign drop_full = (drop_cnt_q == DropMax);
  assign ls_ok     = lsu1_ls_ena & ~lsu1_has_exception & ~exception_flush;
  assign go        = ls_ok & ~drop_full;

  // Every accepted request whose instruction was flushed still returns a data_ok to be discarded.
  assign drop_inc = ((state_q == StWait) & exception_flush & data_addr_ok) |
                    ((state_q == StKill) & data_addr_ok) |
                    ((state_q == StHeld) & exception_flush);
  assign drop_dec = data_data_ok & (drop_cnt_q != '0);

  always_comb begin
    data_req        = 1'b0;
    data_wr         = 1'b0;
    data_size       = 2'd0;
    data_addr       = 32'h0;
    data_wstrb      = 4'b0000;
    data_wdata      = 32'h0;
    lsu1_stall_req  = 1'b0;
    lsu1_req_issued = 1'b0;
    unique case (state_q)
      StIdle: begin
        data_req        = go;
        data_wr         = enc_wr;
        data_size       = enc_size;
        data_addr       = lsu1_psyaddr;
        data_wstrb      = enc_wstrb;
        data_wdata      = enc_wdata;
        lsu1_req_issued = go & data_addr_ok;
        lsu1_stall_req  = go ? ~data_addr_ok : (ls_ok & drop_full);
      end
      StWait, StKill: begin
        data_req        = 1'b1;
        data_wr         = wr_q;
        data_size       = size_q;
        data_addr       = addr_q;
        data_wstrb      = wstrb_q;
        data_wdata      = wdata_q;
        lsu1_req_issued = (state_q == StWait) & data_addr_ok & ~exception_flush;
        lsu1_stall_req  = (state_q == StWait) & ~data_addr_ok;
      end
      StHeld: lsu1_req_issued = 1'b1;
      default: ;
    endcase
    // Outputs are forced low for the whole reset cycle, including the combinational issue path.
    if (rst) begin
      data_req        = 1'b0;
      data_wr         = 1'b0;
      data_size       = 2'd0;
      data_addr       = 32'h0;
      data_wstrb      = 4'b0000;
      data_wdata      = 32'h0;
      lsu1_stall_req  = 1'b0;
      lsu1_req_issued = 1'b0;
    end
  end

  assign drop_pending = (drop_cnt_q != '0) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      drop_cnt_q <= '0;
      wr_q       <= 1'b0;
      size_q     <= 2'd0;
      addr_q     <= 32'h0;
      wstrb_q    <= 4'b0000;
      wdata_q    <= 32'h0;
    end else begin
      if (drop_inc && !drop_dec) begin
        drop_cnt_q <= drop_cnt_q + DropOne;
      end else if (drop_dec && !drop_inc) begin
        drop_cnt_q <= drop_cnt_q - DropOne;
      end
      unique case (state_q)
        StIdle: begin
          if (go) begin
            if (data_addr_ok) begin
              if (pipe_stall) state_q <= StHeld;
            end else begin
              wr_q    <= enc_wr;
              size_q  <= enc_size;
              addr_q  <= lsu1_psyaddr;
              wstrb_q <= enc_wstrb;
              wdata_q <= enc_wdata;
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (exception_flush) begin
            state_q <= data_addr_ok ? StIdle : StKill;
          end else if (data_addr_ok) begin
            state_q <= pipe_stall ? StHeld : StIdle;
          end
        end
        StHeld: begin
          if (!pipe_stall || exception_flush) state_q <= StIdle;
        end
        StKill: begin
          if (data_addr_ok) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu1_dreq.sv
// Directed bench for lsu1_dreq: table of single-cycle IDLE encodings plus multi-cycle sequences.
module tb_lsu1_dreq;

  logic        clk = 1'b0;
  logic        rst;
  logic        exception_flush, pipe_stall, lsu1_ls_ena, lsu1_has_exception;
  logic [3:0]  lsu1_ls_sel;
  logic [31:0] lsu1_psyaddr, lsu1_rt_data;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic        lsu1_stall_req, lsu1_req_issued, drop_pending;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu1_dreq #(.DROP_W(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .exception_flush   (exception_flush),
    .pipe_stall        (pipe_stall),
    .lsu1_ls_ena       (lsu1_ls_ena),
    .lsu1_ls_sel       (lsu1_ls_sel),
    .lsu1_psyaddr      (lsu1_psyaddr),
    .lsu1_rt_data      (lsu1_rt_data),
    .lsu1_has_exception(lsu1_has_exception),
    .data_req          (data_req),
    .data_wr           (data_wr),
    .data_size         (data_size),
    .data_addr         (data_addr),
    .data_wstrb        (data_wstrb),
    .data_wdata        (data_wdata),
    .data_addr_ok      (data_addr_ok),
    .data_data_ok      (data_data_ok),
    .lsu1_stall_req    (lsu1_stall_req),
    .lsu1_req_issued   (lsu1_req_issued),
    .drop_pending      (drop_pending)
  );

  typedef struct {
    logic        ena;
    logic        hexc;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] rt;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        stall;
    logic        iss;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_ctl(input string name, input logic req, input logic stall, input logic iss);
    chk({name, ".req"},    32'(data_req),        32'(req));
    chk({name, ".stall"},  32'(lsu1_stall_req),  32'(stall));
    chk({name, ".issued"}, 32'(lsu1_req_issued), 32'(iss));
  endtask

  task automatic cyc_end();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    lsu1_ls_ena        = 1'b0;
    lsu1_has_exception = 1'b0;
    exception_flush    = 1'b0;
    pipe_stall         = 1'b0;
    data_addr_ok       = 1'b0;
    data_data_ok       = 1'b0;
  endtask

  // Accept a load while stalled, then flush it out of HELD: one more response to drop.
  task automatic kill_held(input logic [31:0] addr);
    lsu1_ls_ena  = 1'b1;
    lsu1_ls_sel  = 4'b0101;
    lsu1_psyaddr = addr;
    pipe_stall   = 1'b1;
    data_addr_ok = 1'b1;
    cyc_end();
    lsu1_ls_ena     = 1'b0;
    data_addr_ok    = 1'b0;
    exception_flush = 1'b1;
    cyc_end();
    exception_flush = 1'b0;
    pipe_stall      = 1'b0;
  endtask

  initial begin
    int pulses;
    //         ena hexc sel      addr          rt            req wr size strb     wdata        stl iss
    vecs[0] = '{1, 0, 4'b0101, 32'h0000_1004, 32'hDEAD_BEEF, 1, 0, 2'd2, 4'b0000, 32'h0,        0, 1};
    vecs[1] = '{1, 0, 4'b0001, 32'h0000_1001, 32'hFFFF_FF80, 1, 0, 2'd0, 4'b0000, 32'h0,        0, 1};
    vecs[2] = '{1, 0, 4'b0100, 32'h0000_2002, 32'h1111_2222, 1, 0, 2'd1, 4'b0000, 32'h0,        0, 1};
    vecs[3] = '{1, 0, 4'b1001, 32'h0000_3002, 32'h1234_5678, 1, 1, 2'd0, 4'b0100, 32'h7878_7878, 0, 1};
    vecs[4] = '{1, 0, 4'b1001, 32'h0000_3000, 32'h0000_00A5, 1, 1, 2'd0, 4'b0001, 32'hA5A5_A5A5, 0, 1};
    vecs[5] = '{1, 0, 4'b1010, 32'h0000_4002, 32'hCAFE_BABE, 1, 1, 2'd1, 4'b1100, 32'hBABE_BABE, 0, 1};
    vecs[6] = '{1, 0, 4'b1010, 32'h0000_4000, 32'h1357_2468, 1, 1, 2'd1, 4'b0011, 32'h2468_2468, 0, 1};
    vecs[7] = '{1, 0, 4'b1011, 32'h0000_5008, 32'h1122_3344, 1, 1, 2'd2, 4'b1111, 32'h1122_3344, 0, 1};
    vecs[8] = '{1, 1, 4'b1011, 32'h0000_5008, 32'h1122_3344, 0, 0, 2'd0, 4'b0000, 32'h0,        0, 0};
    vecs[9] = '{0, 0, 4'b0101, 32'h0000_6000, 32'h0,         0, 0, 2'd0, 4'b0000, 32'h0,        0, 0};

    // Reset with a live load on the inputs: everything must stay low.
    idle_in();
    rst          = 1'b1;
    lsu1_ls_ena  = 1'b1;
    lsu1_ls_sel  = 4'b1011;
    lsu1_psyaddr = 32'h0000_1000;
    lsu1_rt_data = 32'hFFFF_FFFF;
    data_addr_ok = 1'b1;
    @(negedge clk);
    chk_ctl("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.wstrb", 32'(data_wstrb), 32'h0);
    chk("reset.pending", 32'(drop_pending), 32'h0);
    cyc_end();
    cyc_end();
    rst = 1'b0;

    // Single-cycle IDLE issue with immediate acceptance.
    foreach (vecs[i]) begin
      idle_in();
      lsu1_ls_ena        = vecs[i].ena;
      lsu1_has_exception = vecs[i].hexc;
      lsu1_ls_sel        = vecs[i].sel;
      lsu1_psyaddr       = vecs[i].addr;
      lsu1_rt_data       = vecs[i].rt;
      data_addr_ok       = 1'b1;
      @(negedge clk);
      chk_ctl($sformatf("vec%0d", i), vecs[i].req, vecs[i].stall, vecs[i].iss);
      if (vecs[i].req) begin
        chk($sformatf("vec%0d.wr", i),    32'(data_wr),    32'(vecs[i].wr));
        chk($sformatf("vec%0d.size", i),  32'(data_size),  32'(vecs[i].size));
        chk($sformatf("vec%0d.addr", i),  data_addr,       vecs[i].addr);
        chk($sformatf("vec%0d.wstrb", i), 32'(data_wstrb), 32'(vecs[i].wstrb));
        chk($sformatf("vec%0d.wdata", i), data_wdata,      vecs[i].wdata);
      end
      cyc_end();
    end

    // SB to byte 3 waiting three cycles for the bus; latched fields must not follow the inputs.
    idle_in();
    lsu1_ls_ena  = 1'b1;
    lsu1_ls_sel  = 4'b1001;
    lsu1_psyaddr = 32'h0000_2003;
    lsu1_rt_data = 32'h1234_56AB;
    for (int i = 0; i < 4; i++) begin
      data_addr_ok = (i == 3);
      @(negedge clk);
      chk_ctl($sformatf("sb_wait%0d", i), 1'b1, (i != 3), (i == 3));
      chk($sformatf("sb_wait%0d.addr", i),  data_addr,       32'h0000_2003);
      chk($sformatf("sb_wait%0d.wdata", i), data_wdata,      32'hABAB_ABAB);
      chk($sformatf("sb_wait%0d.wstrb", i), 32'(data_wstrb), 32'b1000);
      chk($sformatf("sb_wait%0d.wr", i),    32'(data_wr),    32'h1);
      cyc_end();
      lsu1_psyaddr = 32'hFFFF_FFF0;
      lsu1_rt_data = 32'h0;
    end
    idle_in();
    @(negedge clk);
    chk_ctl("sb_after", 1'b0, 1'b0, 1'b0);
    cyc_end();

    // SH accepted under pipe_stall: one request pulse, issued held high.
    lsu1_ls_ena  = 1'b1;
    lsu1_ls_sel  = 4'b1010;
    lsu1_psyaddr = 32'h0000_6002;
    lsu1_rt_data = 32'hBEEF_0102;
    pipe_stall   = 1'b1;
    data_addr_ok = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pulses += int'(data_req);
      chk($sformatf("sh_held%0d.issued", i), 32'(lsu1_req_issued), 32'h1);
      chk($sformatf("sh_held%0d.stall", i),  32'(lsu1_stall_req),  32'h0);
      cyc_end();
    end
    chk("sh_held.pulses", 32'(pulses), 32'd1);
    pipe_stall  = 1'b0;
    lsu1_ls_ena = 1'b0;
    @(negedge clk);
    chk_ctl("sh_release", 1'b0, 1'b0, 1'b1);
    cyc_end();
    @(negedge clk);
    chk_ctl("sh_idle", 1'b0, 1'b0, 1'b0);
    cyc_end();

    // LW flushed in WAIT: request persists, then its response is dropped.
    idle_in();
    lsu1_ls_ena  = 1'b1;
    lsu1_ls_sel  = 4'b0101;
    lsu1_psyaddr = 32'h0000_7000;
    @(negedge clk);
    chk_ctl("kill_issue", 1'b1, 1'b1, 1'b0);
    cyc_end();
    exception_flush = 1'b1;
    @(negedge clk);
    chk("kill_flush.req", 32'(data_req), 32'h1);
    cyc_end();
    exception_flush = 1'b0;
    lsu1_ls_ena     = 1'b0;
    @(negedge clk);
    chk_ctl("kill_hold", 1'b1, 1'b0, 1'b0);
    chk("kill_hold.addr", data_addr, 32'h0000_7000);
    cyc_end();
    data_addr_ok = 1'b1;
    @(negedge clk);
    chk_ctl("kill_accept", 1'b1, 1'b0, 1'b0);
    cyc_end();
    data_addr_ok = 1'b0;
    @(negedge clk);
    chk("kill_pending", 32'(drop_pending), 32'h1);
    chk("kill_idle.req", 32'(data_req), 32'h0);
    data_data_ok = 1'b1;
    cyc_end();
    data_data_ok = 1'b0;
    @(negedge clk);
    chk("kill_drained", 32'(drop_pending), 32'h0);
    cyc_end();

    // Saturate the drop counter, then check blocking and kill+data_ok in one cycle.
    kill_held(32'h0000_8000);
    kill_held(32'h0000_8004);
    kill_held(32'h0000_8008);
    @(negedge clk);
    chk("sat.pending", 32'(drop_pending), 32'h1);
    lsu1_ls_ena  = 1'b1;
    lsu1_ls_sel  = 4'b0101;
    lsu1_psyaddr = 32'h0000_800C;
    data_addr_ok = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_ctl($sformatf("sat_block%0d", i), 1'b0, 1'b1, 1'b0);
      cyc_end();
    end
    data_data_ok = 1'b1;
    @(negedge clk);
    chk_ctl("sat_dataok", 1'b0, 1'b1, 1'b0);
    cyc_end();
    data_data_ok = 1'b0;
    @(negedge clk);
    chk_ctl("sat_unblock", 1'b1, 1'b0, 1'b1);
    cyc_end();
    pipe_stall = 1'b1;
    cyc_end();
    lsu1_ls_ena     = 1'b0;
    data_addr_ok    = 1'b0;
    exception_flush = 1'b1;
    data_data_ok    = 1'b1;
    @(negedge clk);
    chk("both.issued", 32'(lsu1_req_issued), 32'h1);
    cyc_end();
    exception_flush = 1'b0;
    pipe_stall      = 1'b0;
    cyc_end();
    data_data_ok = 1'b0;
    @(negedge clk);
    chk("both.cnt1", 32'(drop_pending), 32'h1);
    data_data_ok = 1'b1;
    cyc_end();
    data_data_ok = 1'b0;
    @(negedge clk);
    chk("both.cnt0", 32'(drop_pending), 32'h0);
    cyc_end();

    // has_exception masks a store entirely.
    idle_in();
    lsu1_ls_ena        = 1'b1;
    lsu1_has_exception = 1'b1;
    lsu1_ls_sel        = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      data_addr_ok = (i == 2);
      @(negedge clk);
      chk_ctl($sformatf("hexc%0d", i), 1'b0, 1'b0, 1'b0);
      cyc_end();
    end

    // Reset while waiting with a pending drop: all state abandoned.
    idle_in();
    kill_held(32'h0000_9000);
    lsu1_ls_ena  = 1'b1;
    lsu1_ls_sel  = 4'b0101;
    lsu1_psyaddr = 32'h0000_9004;
    cyc_end();
    rst = 1'b1;
    @(negedge clk);
    chk_ctl("rst_wait", 1'b0, 1'b0, 1'b0);
    chk("rst_wait.pending", 32'(drop_pending), 32'h0);
    cyc_end();
    rst         = 1'b0;
    lsu1_ls_ena = 1'b0;
    @(negedge clk);
    chk_ctl("rst_after", 1'b0, 1'b0, 1'b0);
    chk("rst_after.pending", 32'(drop_pending), 32'h0);
    cyc_end();
    lsu1_ls_ena  = 1'b1;
    lsu1_psyaddr = 32'h0000_A000;
    @(negedge clk);
    chk_ctl("rst_fresh", 1'b1, 1'b1, 1'b0);
    chk("rst_fresh.addr", data_addr, 32'h0000_A000);
    data_addr_ok = 1'b1;
    cyc_end();
    idle_in();
    cyc_end();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
